regfile_arbiter: RTL

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester arbiter in front of a single-port register file.
// Each accepted request is latched in IDLE, issued to the register file for one
// cycle in ISSUE, and for reads the registered read data is captured in RDWAIT.
// Arbitration is round-robin by default; defining REGFILE_ARB_FIXED_PRIO_EN makes
// requester 0 always win and removes the last-grant pointer.
module regfile_arbiter #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rf_WrEn,
  output logic                  rf_RdEn,
  output logic [ADDR_WIDTH-1:0] rf_Address,
  output logic [DATA_WIDTH-1:0] rf_WrData,
  input  logic [DATA_WIDTH-1:0] rf_RdData
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRdWait
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;   // 0: requester 0, 1: requester 1
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  win1;               // requester 1 wins this IDLE cycle

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 1 wins only when requester 0 is idle.
  always_comb begin
    win1 = ~req0;
  end
`else
  logic last_q, last_d;  // requester granted most recently

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    win1 = req1 & (~req0 | ~last_q);
  end

  // Pointer moves only when a grant is actually issued.
  always_comb begin
    last_d = last_q;
    if (state_q == StIssue) begin
      last_d = owner_q;
    end
  end

  // Pointer register; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Next-state logic: latch winner in IDLE, issue, then capture read data.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          owner_d = win1;
          we_d    = win1 ? we1 : we0;
          addr_d  = win1 ? addr1 : addr0;
          wdata_d = win1 ? wdata1 : wdata0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = we_q ? StIdle : StRdWait;
      end
      StRdWait: begin
        // Register file data is valid in this cycle; only the owner's copy changes.
        if (owner_q) begin
          rdata1_d  = rf_RdData;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = rf_RdData;
          rvalid0_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Grants and enables are decoded from ISSUE; address/data hold between issues.
  always_comb begin
    gnt0       = (state_q == StIssue) & ~owner_q;
    gnt1       = (state_q == StIssue) & owner_q;
    rf_WrEn    = (state_q == StIssue) & we_q;
    rf_RdEn    = (state_q == StIssue) & ~we_q;
    rf_Address = addr_q;
    rf_WrData  = wdata_q;
    rvalid0    = rvalid0_q;
    rvalid1    = rvalid1_q;
    rdata0     = rdata0_q;
    rdata1     = rdata1_q;
  end

endmodule
